// File: rtl/conv_out_collector_if.sv
// ---------------------------------------------------------------------------
// conv_out_collector_if
//   Groups the result stream coming from conv_blk and the memory write port
//   driven by conv_out_collector. Signal names are from the collector's view.
//
//   i_en           result-valid strobe (producer -> collector)
//   i_conv_result  signed convolution result (producer -> collector)
//   o_wr_en        memory write strobe (collector -> memory)
//   o_wr_addr      row-major write address (collector -> memory)
//   o_wr_data      signed write data (collector -> memory)
//
//   Modports: slave  = collector side, master = producer/memory side.
// ---------------------------------------------------------------------------
interface conv_out_collector_if #(
    parameter int unsigned OUT_SIZE   = 248,
    parameter int unsigned DATA_WIDTH = 48
);
    localparam int unsigned ADDR_WIDTH = $clog2(OUT_SIZE * OUT_SIZE);

    logic                         i_en;
    logic signed [DATA_WIDTH-1:0] i_conv_result;
    logic                         o_wr_en;
    logic [ADDR_WIDTH-1:0]        o_wr_addr;
    logic signed [DATA_WIDTH-1:0] o_wr_data;

    modport slave (
        input  i_en,
        input  i_conv_result,
        output o_wr_en,
        output o_wr_addr,
        output o_wr_data
    );

    modport master (
        output i_en,
        output i_conv_result,
        input  o_wr_en,
        input  o_wr_addr,
        input  o_wr_data
    );
endinterface

// File: rtl/conv_out_collector.sv
// ---------------------------------------------------------------------------
// conv_out_collector
//   Collects one frame of OUT_SIZE*OUT_SIZE convolution results and writes
//   them to memory in row-major order, one cycle after each accepted result.
//
//   Ports:
//     i_clk        clock, rising edge
//     i_rst        asynchronous active-low reset
//     i_go         arm collection of one frame (honoured only in IDLE)
//     bus (slave)  i_en/i_conv_result stream in, o_wr_en/o_wr_addr/o_wr_data out
//     o_row/o_col  position of the next expected result
//     o_busy       high while collecting
//     o_done       one-cycle pulse together with the frame's last write
//     o_overflow   sticky: a result arrived while not collecting
//
//   Optional feature: define CONV_OUT_RELU_EN to write negative results as 0.
//   Latency, addressing and control timing are identical either way.
// ---------------------------------------------------------------------------
module conv_out_collector #(
    parameter int unsigned  OUT_SIZE   = 248,
    parameter int unsigned  DATA_WIDTH = 48,
    localparam int unsigned ADDR_WIDTH = $clog2(OUT_SIZE * OUT_SIZE),
    localparam int unsigned RC_WIDTH   = $clog2(OUT_SIZE)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_go,
    conv_out_collector_if.slave bus,
    output logic [RC_WIDTH-1:0] o_row,
    output logic [RC_WIDTH-1:0] o_col,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_overflow
);

    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(OUT_SIZE * OUT_SIZE - 1);
    localparam logic [RC_WIDTH-1:0]   LastRc   = RC_WIDTH'(OUT_SIZE - 1);

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StDone
    } state_e;

    state_e                       state_q;
    logic [ADDR_WIDTH-1:0]        addr_q;
    logic [RC_WIDTH-1:0]          row_q;
    logic [RC_WIDTH-1:0]          col_q;
    logic                         wr_en_q;
    logic [ADDR_WIDTH-1:0]        wr_addr_q;
    logic signed [DATA_WIDTH-1:0] wr_data_q;
    logic                         busy_q;
    logic                         done_q;
    logic                         overflow_q;

    logic                         arming;
    logic                         accept;
    logic                         last;
    logic                         col_wrap;
    logic [ADDR_WIDTH-1:0]        base_addr;
    logic [RC_WIDTH-1:0]          base_row;
    logic [RC_WIDTH-1:0]          base_col;
    logic [ADDR_WIDTH-1:0]        next_addr;
    logic [RC_WIDTH-1:0]          next_row;
    logic [RC_WIDTH-1:0]          next_col;
    logic signed [DATA_WIDTH-1:0] wr_data_d;

    always_comb begin
        arming = (state_q == StIdle) && i_go;
        // A result strobed in the arming cycle is result 0 of the new frame.
        accept = bus.i_en && ((state_q == StCollect) || arming);

        // Counters read as zero in the arming cycle so result 0 lands at addr 0.
        base_addr = arming ? '0 : addr_q;
        base_row  = arming ? '0 : row_q;
        base_col  = arming ? '0 : col_q;

        last     = (base_addr == LastAddr);
        col_wrap = (base_col == LastRc);

        // Running counters; the final acceptance wraps everything back to 0.
        next_addr = last ? '0 : base_addr + ADDR_WIDTH'(1);
        next_col  = col_wrap ? '0 : base_col + RC_WIDTH'(1);
        if (col_wrap) begin
            next_row = (base_row == LastRc) ? '0 : base_row + RC_WIDTH'(1);
        end else begin
            next_row = base_row;
        end

`ifdef CONV_OUT_RELU_EN
        wr_data_d = bus.i_conv_result[DATA_WIDTH-1] ? '0 : bus.i_conv_result;
`else
        wr_data_d = bus.i_conv_result;
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            row_q      <= '0;
            col_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_en_q <= accept;
            done_q  <= 1'b0;

            if (accept) begin
                wr_addr_q <= base_addr;
                wr_data_q <= wr_data_d;
                addr_q    <= next_addr;
                row_q     <= next_row;
                col_q     <= next_col;
            end else if (arming) begin
                addr_q <= '0;
                row_q  <= '0;
                col_q  <= '0;
            end

            unique case (state_q)
                StIdle: begin
                    if (i_go) begin
                        overflow_q <= 1'b0;
                        if (accept && last) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= StCollect;
                            busy_q  <= 1'b1;
                        end
                    end else if (bus.i_en) begin
                        overflow_q <= 1'b1;
                    end
                end
                StCollect: begin
                    // i_go is ignored here; only accepted results move state.
                    if (accept && last) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    if (bus.i_en) begin
                        overflow_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_wr_en   = wr_en_q;
    assign bus.o_wr_addr = wr_addr_q;
    assign bus.o_wr_data = wr_data_q;
    assign o_row         = row_q;
    assign o_col         = col_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_overflow    = overflow_q;

endmodule

// File: tb/tb_conv_out_collector.sv
// ---------------------------------------------------------------------------
// tb_conv_out_collector
//   Bench for conv_out_collector with OUT_SIZE=4, DATA_WIDTH=48.
//   A cycle table covers overflow-before-go, go with coincident data, go
//   ignored while collecting, signed data and the first row wrap. Hand-written
//   sequences cover full frames (back-to-back and gapped), DONE-state
//   behaviour and asynchronous reset mid-frame. Writes are checked against a
//   queue of expected {addr, data, last} records.
// ---------------------------------------------------------------------------
module tb_conv_out_collector;
    localparam int unsigned N  = 4;
    localparam int unsigned DW = 48;
    localparam int unsigned AW = 4;
    localparam int unsigned RW = 2;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          go    = 1'b0;
    logic [RW-1:0] row;
    logic [RW-1:0] col;
    logic          busy;
    logic          done;
    logic          ovf;

    conv_out_collector_if #(.OUT_SIZE(N), .DATA_WIDTH(DW)) bus ();

    conv_out_collector #(
        .OUT_SIZE  (N),
        .DATA_WIDTH(DW)
    ) u_dut (
        .i_clk     (clk),
        .i_rst     (rst_n),
        .i_go      (go),
        .bus       (bus),
        .o_row     (row),
        .o_col     (col),
        .o_busy    (busy),
        .o_done    (done),
        .o_overflow(ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;
    bit sb_on    = 1'b0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
    } wr_t;

    wr_t exp_q[$];

    typedef struct {
        logic          go;
        logic          en;
        logic [DW-1:0] data;
        logic          wr_en;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          busy;
        logic          done;
        logic          ovf;
        logic [RW-1:0] row;
        logic [RW-1:0] col;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [DW-1:0] exp_wdata(input logic [DW-1:0] d);
`ifdef CONV_OUT_RELU_EN
        return d[DW-1] ? '0 : d;
`else
        return d;
`endif
    endfunction

    task automatic drive(input logic g, input logic e, input logic [DW-1:0] d);
        @(negedge clk);
        go                = g;
        bus.i_en          = e;
        bus.i_conv_result = d;
    endtask

    task automatic push_exp(input int idx, input logic [DW-1:0] d);
        wr_t w;
        w.addr = AW'(idx);
        w.data = exp_wdata(d);
        w.last = (idx == N * N - 1);
        exp_q.push_back(w);
    endtask

    task automatic do_reset();
        @(negedge clk);
        go       = 1'b0;
        bus.i_en = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"}, 64'(bus.o_wr_en), 64'd0);
        check({tag, "_wr_addr"}, 64'(bus.o_wr_addr), 64'd0);
        check({tag, "_wr_data"}, 64'($unsigned(bus.o_wr_data)), 64'd0);
        check({tag, "_row"}, 64'(row), 64'd0);
        check({tag, "_col"}, 64'(col), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_ovf"}, 64'(ovf), 64'd0);
    endtask

    // Write monitor: every write must match the head of the expectation queue.
    always @(posedge clk) begin
        wr_t e;
        #1;
        if (sb_on) begin
            if (done) n_done++;
            if (bus.o_wr_en) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                             bus.o_wr_addr, bus.o_wr_data);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_addr", 64'(bus.o_wr_addr), 64'(e.addr));
                    check("sb_data", 64'($unsigned(bus.o_wr_data)), 64'(e.data));
                    check("sb_done", 64'(done), 64'(e.last));
                end
            end else if (done) begin
                check("done_without_write", 64'(done), 64'd0);
            end
        end
    end

    initial begin
        bus.i_en          = 1'b0;
        bus.i_conv_result = '0;

        //            go  en  data        wr  addr wdata                  busy done ovf row col
        tbl[0] = '{1'b0, 1'b1, DW'(7),    1'b0, 0, '0,                    1'b0, 1'b0, 1'b1, 0, 0};
        tbl[1] = '{1'b0, 1'b0, DW'(0),    1'b0, 0, '0,                    1'b0, 1'b0, 1'b1, 0, 0};
        tbl[2] = '{1'b1, 1'b1, DW'(42),   1'b1, 0, exp_wdata(DW'(42)),    1'b1, 1'b0, 1'b0, 0, 1};
        tbl[3] = '{1'b1, 1'b0, DW'(0),    1'b0, 0, '0,                    1'b1, 1'b0, 1'b0, 0, 1};
        tbl[4] = '{1'b0, 1'b1, DW'(-5),   1'b1, 1, exp_wdata(DW'(-5)),    1'b1, 1'b0, 1'b0, 0, 2};
        tbl[5] = '{1'b0, 1'b1, DW'(3),    1'b1, 2, exp_wdata(DW'(3)),     1'b1, 1'b0, 1'b0, 0, 3};
        tbl[6] = '{1'b0, 1'b1, DW'(-100), 1'b1, 3, exp_wdata(DW'(-100)),  1'b1, 1'b0, 1'b0, 1, 0};

        // Reset state.
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Cycle table.
        for (int i = 0; i < 7; i++) begin
            drive(tbl[i].go, tbl[i].en, tbl[i].data);
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d_wr_en", i), 64'(bus.o_wr_en), 64'(tbl[i].wr_en));
            if (tbl[i].wr_en) begin
                check($sformatf("tbl%0d_addr", i), 64'(bus.o_wr_addr), 64'(tbl[i].addr));
                check($sformatf("tbl%0d_data", i), 64'($unsigned(bus.o_wr_data)),
                      64'(tbl[i].wdata));
            end
            check($sformatf("tbl%0d_busy", i), 64'(busy), 64'(tbl[i].busy));
            check($sformatf("tbl%0d_done", i), 64'(done), 64'(tbl[i].done));
            check($sformatf("tbl%0d_ovf", i), 64'(ovf), 64'(tbl[i].ovf));
            check($sformatf("tbl%0d_row", i), 64'(row), 64'(tbl[i].row));
            check($sformatf("tbl%0d_col", i), 64'(col), 64'(tbl[i].col));
        end

        // Full frame, back-to-back results.
        do_reset();
        sb_on = 1'b1;
        drive(1'b1, 1'b0, '0);
        for (int i = 0; i < 16; i++) begin
            push_exp(i, DW'(i));
            drive(1'b0, 1'b1, DW'(i));
        end
        @(posedge clk);
        #1;
        check("b2b_done_pulse", 64'(done), 64'd1);
        check("b2b_busy_low", 64'(busy), 64'd0);
        // In DONE: data dropped as overflow, go ignored.
        drive(1'b1, 1'b1, DW'(77));
        @(posedge clk);
        #1;
        check("done_en_ovf", 64'(ovf), 64'd1);
        check("done_go_ignored_busy", 64'(busy), 64'd0);
        drive(1'b0, 1'b0, '0);
        @(posedge clk);
        #1;
        check("after_done_idle_busy", 64'(busy), 64'd0);
        check("b2b_done_count", 64'(n_done), 64'd1);
        check("b2b_queue_empty", 64'(exp_q.size()), 64'd0);

        // Full frame, one result every third cycle.
        do_reset();
        drive(1'b1, 1'b0, '0);
        for (int i = 0; i < 16; i++) begin
            push_exp(i, DW'(100 + i));
            drive(1'b0, 1'b1, DW'(100 + i));
            if (i == 3) begin
                @(posedge clk);
                #1;
                check("gap_row_after4", 64'(row), 64'd1);
                check("gap_col_after4", 64'(col), 64'd0);
            end
            drive(1'b0, 1'b0, '0);
            drive(1'b0, 1'b0, '0);
        end
        drive(1'b0, 1'b0, '0);
        check("gap_done_count", 64'(n_done), 64'd2);
        check("gap_queue_empty", 64'(exp_q.size()), 64'd0);
        check("gap_busy_low", 64'(busy), 64'd0);

        // Asynchronous reset after 6 of 16 results.
        do_reset();
        drive(1'b1, 1'b0, '0);
        for (int i = 0; i < 6; i++) begin
            push_exp(i, DW'(200 + i));
            drive(1'b0, 1'b1, DW'(200 + i));
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        go       = 1'b0;
        bus.i_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        // Data without go after reset is dropped.
        drive(1'b0, 1'b1, DW'(5));
        drive(1'b0, 1'b0, '0);
        check("rst_drop_ovf", 64'(ovf), 64'd1);
        // Restart: go coincident with data lands at address 0.
        push_exp(0, DW'(99));
        drive(1'b1, 1'b1, DW'(99));
        drive(1'b0, 1'b0, '0);
        check("restart_ovf_clear", 64'(ovf), 64'd0);
        check("restart_busy", 64'(busy), 64'd1);
        drive(1'b0, 1'b0, '0);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        check("final_done_count", 64'(n_done), 64'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/conv_out_collector.md
CONV_OUT_COLLECTOR -- requirements
Module: conv_out_collector

Interface
REQ-001 SHALL have parameter OUT_SIZE, default 248, output feature-map side length (results per frame = OUT_SIZE*OUT_SIZE).
REQ-002 SHALL have parameter DATA_WIDTH, default 48, width of one convolution result.
REQ-003 SHALL derive localparam ADDR_WIDTH = $clog2(OUT_SIZE*OUT_SIZE).
REQ-004 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-005 i_rst  input  1  reset, asynchronous assert, active-low.
REQ-006 i_go  input  1  arm collection of one frame.
REQ-007 i_en  input  1  result-valid strobe from conv_blk o_en.
REQ-008 i_conv_result  input  DATA_WIDTH, signed, result from conv_blk o_conv_result.
REQ-009 o_wr_en  output  1  memory write strobe.
REQ-010 o_wr_addr  output  ADDR_WIDTH  memory write address, row-major.
REQ-011 o_wr_data  output  DATA_WIDTH, signed, memory write data.
REQ-012 o_row, o_col  output  $clog2(OUT_SIZE) each  position of next expected result.
REQ-013 o_busy  output  1  high in COLLECT.
REQ-014 o_done  output  1  one-cycle pulse at frame completion.
REQ-015 o_overflow  output  1  sticky: result arrived while not collecting.

Function
REQ-016 FSM states IDLE, COLLECT, DONE.
REQ-017 IDLE: i_go=1 -> COLLECT; row, col, address counters cleared to 0 on that edge.
REQ-018 i_en=1 in the same cycle i_go arms in IDLE SHALL be accepted as result 0.
REQ-019 COLLECT: each cycle with i_en=1 accepts one result; o_wr_en=1 exactly one cycle later with o_wr_addr=accepted index and o_wr_data=result (latency 1, no backpressure).
REQ-020 Per accepted result: col increments; col==OUT_SIZE-1 wraps to 0 and increments row; o_wr_addr = row*OUT_SIZE+col via running counter, no multiplier.
REQ-021 Acceptance of result OUT_SIZE*OUT_SIZE-1 -> DONE on next edge; o_done=1 for the one cycle in DONE, concurrent with the last o_wr_en.
REQ-022 DONE -> IDLE unconditionally after one cycle; i_go in DONE ignored.
REQ-023 i_go during COLLECT SHALL be ignored; counters unaffected.
REQ-024 i_en=1 in IDLE (without i_go) or DONE: result dropped, no write, o_overflow set to 1.
REQ-025 o_overflow SHALL clear only on reset or on i_go accepted in IDLE.
REQ-026 Gaps of any length between i_en pulses SHALL not affect counting.

Reset
REQ-027 On i_rst=0, immediately: state IDLE; o_wr_en, o_busy, o_done, o_overflow = 0; o_wr_addr, o_wr_data, o_row, o_col = 0.
REQ-028 Reset mid-frame SHALL abort the frame without pending write; a new frame needs i_go.

Configuration
REQ-029 Macro CONV_OUT_RELU_EN: when defined, results with sign bit 1 written as 0 (ReLU), non-negative unchanged; when undefined, o_wr_data equals accepted result bit-exactly.
REQ-030 Macro SHALL not change latency, addressing, or control timing.

Verification
REQ-031 OUT_SIZE=4: i_go, then 16 back-to-back i_en with data 0..15 -> 16 writes, addr 0..15, data 0..15, o_done one cycle with write 15, o_busy low after.
REQ-032 OUT_SIZE=4: i_en gapped every 3 cycles -> same address/data sequence; o_row/o_col read 1/0 after 4th acceptance.
REQ-033 i_en with data 7 before any i_go -> no o_wr_en, o_overflow=1; next i_go -> o_overflow=0.
REQ-034 Data -5: with CONV_OUT_RELU_EN -> o_wr_data=0; without -> o_wr_data=-5.
REQ-035 i_rst=0 after 6 of 16 results -> all outputs 0 asynchronously; restart with i_go -> first write addr 0.
REQ-036 i_go coincident with first i_en (data 42) in IDLE -> write addr 0 data 42 next cycle.
